// File: rtl/tty_uart_tx.sv
// 8N1 UART transmitter, LSB first, with a single-byte holding register and
// PicoBlaze-style set/clear status and interrupt flags. Baud tick is 16x, derived from clk.
module tty_uart_tx #(
  parameter int unsigned BAUD_DIV = 163
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] din,
  input  logic       write,
  output logic       txd,
  output logic       busy,
  output logic       full,
  output logic       overrun,
  output logic       ready,
  output logic [3:0] CS,
  output logic       interrupt,
  input  logic       interrupt_ack,
  output logic       txready_status,
  input  logic       reset_txready_status
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_START = 4'd1,
    S_BIT0  = 4'd2,
    S_BIT1  = 4'd3,
    S_BIT2  = 4'd4,
    S_BIT3  = 4'd5,
    S_BIT4  = 4'd6,
    S_BIT5  = 4'd7,
    S_BIT6  = 4'd8,
    S_BIT7  = 4'd9,
    S_STOP  = 4'd10
  } state_e;

  localparam logic [7:0] BaudLast = 8'(BAUD_DIV - 1);

  state_e     state_q, state_d;
  logic [7:0] baud_q, baud_d;
  logic [3:0] tick_q, tick_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] hold_q, hold_d;
  logic       full_q, full_d;
  logic       overrun_q, overrun_d;
  logic       ready_q, ready_d;
  logic       txd_q, txd_d;
  logic       irq_q, irq_d;
  logic       txrdy_q, txrdy_d;
  logic       bclk;
  logic       bit_end;
  logic       load;
  logic       accept;
  logic       data_bit;

  assign bclk     = (baud_q == BaudLast);
  assign bit_end  = bclk && (tick_q == 4'hF);
  assign data_bit = (state_q >= S_BIT0) && (state_q <= S_BIT7);
  // A queued byte is picked up either from idle on a tick or straight out of a stop bit.
  assign load     = full_q && (((state_q == S_IDLE) && bclk) || ((state_q == S_STOP) && bit_end));
  assign accept   = write && !full_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bclk && full_q) state_d = S_START;
      S_START: if (bit_end) state_d = S_BIT0;
      S_BIT0, S_BIT1, S_BIT2, S_BIT3,
      S_BIT4, S_BIT5, S_BIT6, S_BIT7:
               if (bit_end) state_d = state_e'(state_q + 4'd1);
      S_STOP:  if (bit_end) state_d = full_q ? S_START : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    txd_d   = 1'b1;
    busy    = (state_q != S_IDLE);
    ready_d = (state_q == S_STOP) && bit_end;
    case (state_q)
      S_START: txd_d = 1'b0;
      S_BIT0, S_BIT1, S_BIT2, S_BIT3,
      S_BIT4, S_BIT5, S_BIT6, S_BIT7:
               txd_d = shift_q[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_comb begin
    baud_d = bclk ? 8'd0 : baud_q + 8'd1;

    tick_d = tick_q;
    if (state_q == S_IDLE) begin
      tick_d = 4'd0;
    end else if (bclk) begin
      tick_d = tick_q + 4'd1;
    end

    shift_d = shift_q;
    if (load) begin
      shift_d = hold_q;
    end else if (bit_end && data_bit) begin
      shift_d = {1'b0, shift_q[7:1]};
    end

    hold_d    = accept ? din : hold_q;
    full_d    = accept ? 1'b1 : (load ? 1'b0 : full_q);
    overrun_d = write && full_q;

    // Clear has priority over a coincident ready.
    irq_d   = interrupt_ack ? 1'b0 : (ready_q ? 1'b1 : irq_q);
    txrdy_d = reset_txready_status ? 1'b0 : (ready_q ? 1'b1 : txrdy_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      baud_q    <= 8'd0;
      tick_q    <= 4'd0;
      shift_q   <= 8'd0;
      hold_q    <= 8'd0;
      full_q    <= 1'b0;
      overrun_q <= 1'b0;
      ready_q   <= 1'b0;
      txd_q     <= 1'b1;
      irq_q     <= 1'b0;
      txrdy_q   <= 1'b0;
    end else begin
      baud_q    <= baud_d;
      tick_q    <= tick_d;
      shift_q   <= shift_d;
      hold_q    <= hold_d;
      full_q    <= full_d;
      overrun_q <= overrun_d;
      ready_q   <= ready_d;
      txd_q     <= txd_d;
      irq_q     <= irq_d;
      txrdy_q   <= txrdy_d;
    end
  end

  assign txd            = txd_q;
  assign full           = full_q;
  assign overrun        = overrun_q;
  assign ready          = ready_q;
  assign CS             = state_q;
  assign interrupt      = irq_q;
  assign txready_status = txrdy_q;

endmodule
